// File: rtl/im_program_loader.sv
// Byte-stream loader for the 16-bit instruction memory: count byte, N words (high byte
// first), then an XOR checksum byte. Holds the CPU while a frame is being loaded.
module im_program_loader #(
   parameter int DEPTH = 30,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [7:0]    in_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic          im_we_o,
   output logic [AW-1:0] im_addr_o,
   output logic [15:0]   im_wdata_o,
   output logic          cpu_hold_o,
   output logic          load_done_o,
   output logic          load_err_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_HI    = 3'd2;
   localparam logic [2:0] S_LO    = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CHK   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   logic [2:0]    state_q, state_d;
   logic [7:0]    n_q, n_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    csum_q, csum_d;
   logic [AW-1:0] addr_q, addr_d;

   logic accepting;
   logic xfer;
   logic count_ok;
   logic last_word;

   assign accepting = (state_q == S_COUNT) || (state_q == S_HI) ||
                      (state_q == S_LO)    || (state_q == S_CHK);

   // abort wins over a byte offered in the same cycle, so the byte is never consumed
   assign in_ready_o = accepting & ~abort_i;
   assign xfer       = in_valid_i & in_ready_o;

   assign count_ok  = (in_data_i != 8'd0) && (in_data_i <= DEPTH_B);
   assign last_word = ((wcnt_q + 8'd1) == n_q);

   assign im_we_o     = (state_q == S_WRITE);
   assign im_addr_o   = addr_q;
   assign im_wdata_o  = {hi_q, lo_q};
   assign cpu_hold_o  = (state_q != S_IDLE);
   assign load_done_o = (state_q == S_DONE);
   assign load_err_o  = (state_q == S_ERR);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      csum_d  = csum_q;
      addr_d  = addr_q;

      if ((state_q != S_IDLE) && abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_d = S_COUNT;
               end
            end
            S_COUNT: begin
               if (xfer) begin
                  n_d = in_data_i;
                  if (count_ok) begin
                     state_d = S_HI;
                     addr_d  = '0;
                     wcnt_d  = 8'd0;
                     csum_d  = 8'd0;
                  end else begin
                     state_d = S_ERR;
                  end
               end
            end
            S_HI: begin
               if (xfer) begin
                  hi_d    = in_data_i;
                  csum_d  = csum_q ^ in_data_i;
                  state_d = S_LO;
               end
            end
            S_LO: begin
               if (xfer) begin
                  lo_d    = in_data_i;
                  csum_d  = csum_q ^ in_data_i;
                  state_d = S_WRITE;
               end
            end
            S_WRITE: begin
               addr_d  = addr_q + AW'(1);
               wcnt_d  = wcnt_q + 8'd1;
               state_d = last_word ? S_CHK : S_HI;
            end
            S_CHK: begin
               if (xfer) begin
                  state_d = (in_data_i == csum_q) ? S_DONE : S_ERR;
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= 8'd0;
         wcnt_q  <= 8'd0;
         hi_q    <= 8'd0;
         lo_q    <= 8'd0;
         csum_q  <= 8'd0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wcnt_q  <= wcnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         csum_q  <= csum_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_im_program_loader.sv
// Randomised frame bench for im_program_loader; expected writes and outcomes come from
// a frame-level model (count, word list, XOR of data bytes).
module tb_im_program_loader;

   localparam int DEPTH = 30;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [7:0]    in_data_i = 8'd0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic          im_we_o;
   logic [AW-1:0] im_addr_o;
   logic [15:0]   im_wdata_o;
   logic          cpu_hold_o;
   logic          load_done_o;
   logic          load_err_o;

   int checks = 0;
   int errors = 0;

   logic [23:0] wr_q[$];
   int          done_cnt = 0;
   int          err_cnt = 0;
   logic [7:0]  frame[$];

   im_program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .in_data_i  (in_data_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .im_we_o    (im_we_o),
      .im_addr_o  (im_addr_o),
      .im_wdata_o (im_wdata_o),
      .cpu_hold_o (cpu_hold_o),
      .load_done_o(load_done_o),
      .load_err_o (load_err_o)
   );

   always #5 clk = ~clk;

   // Observe the IM port and status pulses mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (im_we_o === 1'b1) wr_q.push_back({im_addr_o, im_wdata_o});
      if (load_done_o === 1'b1) done_cnt++;
      if (load_err_o === 1'b1) err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      wr_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic check_idle_outputs(input string name);
      logic [29:0] got;
      got = {in_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_hold_o, load_done_o, load_err_o};
      checks++;
      if (got !== 30'd0) begin
         errors++;
         $display("FAIL %s outputs got=%h want=0", name, got);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap, input bit poke_start);
      int  gap;
      bit  ok;
      bit  accepted;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      if (poke_start) begin
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
      end
      in_valid_i = 1'b1;
      in_data_i  = b;
      accepted   = 1'b0;
      for (int t = 0; t < 50; t++) begin
         ok = in_ready_o;
         tick();
         if (ok) begin
            accepted = 1'b1;
            break;
         end
      end
      in_valid_i = 1'b0;
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL byte_accept byte=%h got=not_taken want=taken", b);
      end
   endtask

   task automatic make_frame(input int n, input bit good);
      logic [7:0] cs;
      logic [7:0] r;
      frame.delete();
      frame.push_back(8'(n));
      if (n >= 1 && n <= DEPTH) begin
         cs = 8'd0;
         for (int i = 0; i < 2 * n; i++) begin
            r = 8'($urandom);
            frame.push_back(r);
            cs ^= r;
         end
         r = 8'($urandom_range(255, 1));
         frame.push_back(good ? cs : (cs ^ r));
      end
   endtask

   // Load the current frame and compare against the frame-level model
   task automatic run_frame(input string name, input int max_gap, input bit poke_start);
      int          n;
      bit          valid;
      logic [7:0]  cs;
      bit          exp_done;
      logic [23:0] exp_w[$];
      logic [23:0] w;
      n     = int'(frame[0]);
      valid = (n >= 1) && (n <= DEPTH);
      exp_w.delete();
      exp_done = 1'b0;
      if (valid) begin
         cs = 8'd0;
         for (int k = 0; k < n; k++) begin
            exp_w.push_back({8'(k), frame[1 + 2 * k], frame[2 + 2 * k]});
            cs = cs ^ frame[1 + 2 * k] ^ frame[2 + 2 * k];
         end
         exp_done = (frame[2 * n + 1] == cs);
      end

      clear_obs();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checks++;
      if (cpu_hold_o !== 1'b1) begin
         errors++;
         $display("FAIL %s hold_after_start got=%b want=1", name, cpu_hold_o);
      end

      for (int i = 0; i < frame.size(); i++) begin
         send_byte(frame[i], max_gap, poke_start && (i == 3));
         if (valid && i >= 2 && (i % 2 == 0) && i <= 2 * n) begin
            checks++;
            if (im_we_o !== 1'b1 || im_addr_o !== 8'(i / 2 - 1)) begin
               errors++;
               $display("FAIL %s write_latency word=%0d got we=%b addr=%0d want we=1 addr=%0d",
                        name, i / 2 - 1, im_we_o, im_addr_o, i / 2 - 1);
            end
         end
      end

      checks++;
      if (load_done_o !== exp_done || load_err_o !== !exp_done || cpu_hold_o !== 1'b1) begin
         errors++;
         $display("FAIL %s outcome got done=%b err=%b hold=%b want done=%b err=%b hold=1",
                  name, load_done_o, load_err_o, cpu_hold_o, exp_done, !exp_done);
      end
      tick();
      tick();
      checks++;
      if (cpu_hold_o !== 1'b0 || done_cnt != int'(exp_done) || err_cnt != int'(!exp_done)) begin
         errors++;
         $display("FAIL %s pulses got hold=%b done=%0d err=%0d want hold=0 done=%0d err=%0d",
                  name, cpu_hold_o, done_cnt, err_cnt, exp_done, !exp_done);
      end
      checks++;
      if (wr_q.size() != exp_w.size()) begin
         errors++;
         $display("FAIL %s write_count got=%0d want=%0d", name, wr_q.size(), exp_w.size());
      end else begin
         for (int k = 0; k < exp_w.size(); k++) begin
            w = wr_q[k];
            checks++;
            if (w !== exp_w[k]) begin
               errors++;
               $display("FAIL %s write%0d got addr=%0d data=%h want addr=%0d data=%h",
                        name, k, w[23:16], w[15:0], exp_w[k][23:16], exp_w[k][15:0]);
            end
         end
      end
      $display("frame %s n=%0d writes=%0d done=%0d err=%0d", name, n, wr_q.size(), done_cnt, err_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
      check_idle_outputs("after_reset");
      clear_obs();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      checks++;
      if (in_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_load pre got ready=%b hold=%b want 1 1", in_ready_o, cpu_hold_o);
      end
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("reset_mid_load");
      tick();
      rst = 1'b0;
      repeat (2) tick();
      check_idle_outputs("idle_after_mid_reset");
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_load writes got=%0d want=0", wr_q.size());
      end
      $display("reset test writes=%0d", wr_q.size());
   endtask

   task automatic load_fixed(input logic [7:0] last);
      frame.delete();
      frame.push_back(8'h02);
      frame.push_back(8'h12);
      frame.push_back(8'h34);
      frame.push_back(8'hAB);
      frame.push_back(8'hCD);
      frame.push_back(last);
   endtask

   task automatic test_good_frame();
      load_fixed(8'h40);
      run_frame("good", 0, 1'b0);
   endtask

   task automatic test_bad_checksum();
      load_fixed(8'h41);
      run_frame("bad_csum", 0, 1'b0);
   endtask

   task automatic test_bad_count();
      frame.delete();
      frame.push_back(8'h00);
      run_frame("count00", 0, 1'b0);
      frame.delete();
      frame.push_back(8'h1F);
      run_frame("count1F", 1, 1'b0);
   endtask

   task automatic test_backpressure();
      load_fixed(8'h40);
      run_frame("gaps", 4, 1'b0);
      load_fixed(8'h40);
      run_frame("start_busy", 2, 1'b1);
   endtask

   task automatic test_abort();
      logic [23:0] w;
      // abort while waiting for the second word's high byte
      clear_obs();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      send_byte(8'h03, 0, 1'b0);
      send_byte(8'h11, 1, 1'b0);
      send_byte(8'h22, 1, 1'b0);
      tick();
      in_valid_i = 1'b1;
      in_data_i  = 8'h33;
      abort_i    = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready got=%b want=0", in_ready_o);
      end
      tick();
      abort_i    = 1'b0;
      #1;
      checks++;
      if (cpu_hold_o !== 1'b0 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got hold=%b ready=%b want 0 0", cpu_hold_o, in_ready_o);
      end
      in_valid_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (wr_q.size() != 1 || done_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL abort_hi got writes=%0d done=%0d err=%0d want 1 0 0", wr_q.size(), done_cnt, err_cnt);
      end else begin
         w = wr_q[0];
         checks++;
         if (w !== 24'h001122) begin
            errors++;
            $display("FAIL abort_hi_word got=%h want=001122", w);
         end
      end
      $display("abort_hi writes=%0d done=%0d err=%0d", wr_q.size(), done_cnt, err_cnt);

      // abort in the same cycle as the second write: the write must still land
      clear_obs();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      send_byte(8'h03, 0, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1, 1'b0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (wr_q.size() != 2 || done_cnt != 0 || err_cnt != 0 || cpu_hold_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_write got writes=%0d done=%0d err=%0d hold=%b want 2 0 0 0",
                  wr_q.size(), done_cnt, err_cnt, cpu_hold_o);
      end else begin
         w = wr_q[1];
         checks++;
         if (w !== 24'h01A2A3) begin
            errors++;
            $display("FAIL abort_write_word got=%h want=01A2A3", w);
         end
      end
      $display("abort_write writes=%0d done=%0d err=%0d", wr_q.size(), done_cnt, err_cnt);
   endtask

   task automatic test_full_depth();
      logic [23:0] w;
      make_frame(DEPTH, 1'b1);
      run_frame("full_depth", 1, 1'b0);
      checks++;
      w = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 24'hFFFFFF;
      if (w[23:16] !== 8'(DEPTH - 1)) begin
         errors++;
         $display("FAIL full_depth_last_addr got=%0d want=%0d", w[23:16], DEPTH - 1);
      end
   endtask

   task automatic test_random_frames();
      int n;
      for (int f = 0; f < 16; f++) begin
         n = int'($urandom_range(DEPTH + 4, 0));
         make_frame(n, ($urandom_range(3, 0) != 0));
         run_frame($sformatf("rand%0d", f), int'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_count();
      test_backpressure();
      test_abort();
      test_full_depth();
      test_random_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
